// File: rtl/i2c_slave_responder_pkg.sv
// Shared definitions for the I2C slave responder and its bench.
// Holds the FSM state encodings, the default slave address and a helper
// that decodes which states count as an active, addressed transfer.
package i2c_slave_responder_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h48;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_RX_BYTE   = 3'd3;
    localparam logic [2:0] ST_RX_ACK    = 3'd4;
    localparam logic [2:0] ST_TX_BYTE   = 3'd5;
    localparam logic [2:0] ST_TX_ACKCHK = 3'd6;
    localparam logic [2:0] ST_IGNORE    = 3'd7;

    // High from the address ACK until the transfer ends; ADDR itself is not
    // busy because the address has not matched yet.
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_ADDR_ACK) || (st == ST_RX_BYTE) || (st == ST_RX_ACK) ||
               (st == ST_TX_BYTE)  || (st == ST_TX_ACKCHK);
    endfunction

endpackage

// File: rtl/i2c_edge_detect.sv
// Synchronizes SCL/SDA into the system clock domain and derives bus events.
// Ports:
//   clk_i, rst_i       system clock, asynchronous active-high reset
//   scl_i, sda_i       raw bus lines
//   sda_o              synchronized SDA level (used for bit sampling)
//   scl_rise_o/fall_o  one-cycle pulses on synchronized SCL edges
//   start_o/stop_o     one-cycle pulses on START / STOP conditions
module i2c_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SDA change racing an SCL edge
    // is never mistaken for START/STOP.
    assign start_o    = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
    assign stop_o     = ~sda_prev_q & sda_s & scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave that ACKs one 7-bit address, captures written bytes and returns
// TxData on reads. SDA is open-drain: only ever driven low or released.
// Ports:
//   clock, Reset   system clock, asynchronous active-high reset
//   SCL, SDA       I2C bus (SDA inout, open-drain)
//   TxData/TxLoad  read byte source and its capture pulse
//   RxData/RxValid last written byte and its update pulse
//   Busy, State    transfer-active flag and FSM state for debug
module i2c_slave_responder
    import i2c_slave_responder_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] TxData,
    output logic       TxLoad,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       Busy,
    output logic [2:0] State
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk_i     (clock),
        .rst_i     (Reset),
        .scl_i     (SCL),
        .sda_i     (SDA),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       rw_q, rw_d;
    logic       byte_done_q, byte_done_d;
    logic       mack_q, mack_d;
    logic       sda_drive_q, sda_drive_d;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            rw_q        <= 1'b0;
            byte_done_q <= 1'b0;
            mack_q      <= 1'b0;
            sda_drive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            rw_q        <= rw_d;
            byte_done_q <= byte_done_d;
            mack_q      <= mack_d;
            sda_drive_q <= sda_drive_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        rw_d        = rw_q;
        byte_done_d = byte_done_q;
        mack_d      = mack_q;
        sda_drive_d = sda_drive_q;

        // Bus conditions outrank any bit-level action in the same cycle.
        if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_drive_d = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_drive_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            // shift_q[6:0] already holds the 7 address bits.
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sda_s;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall starts the ACK; second fall ends it.
                    if (scl_fall) begin
                        if (!sda_drive_q) begin
                            sda_drive_d = 1'b1;
                        end else begin
                            bit_cnt_d   = 3'd0;
                            byte_done_d = 1'b0;
                            if (rw_q) begin
                                shift_d     = TxData;
                                tx_load_d   = 1'b1;
                                sda_drive_d = ~TxData[7];
                                state_d     = ST_TX_BYTE;
                            end else begin
                                sda_drive_d = 1'b0;
                                state_d     = ST_RX_BYTE;
                            end
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        byte_done_d = 1'b0;
                        sda_drive_d = 1'b1;
                        state_d     = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        state_d     = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_drive_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            state_d     = ST_TX_ACKCHK;
                        end else begin
                            bit_cnt_d   = bit_cnt_q + 3'd1;
                            shift_d     = {shift_q[6:0], 1'b0};
                            sda_drive_d = ~shift_q[6];
                        end
                    end
                end
                ST_TX_ACKCHK: begin
                    // Sample the master's ACK while SCL is high, act on the
                    // following fall so SDA never moves with SCL high.
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            shift_d     = TxData;
                            tx_load_d   = 1'b1;
                            sda_drive_d = ~TxData[7];
                            bit_cnt_d   = 3'd0;
                            state_d     = ST_TX_BYTE;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated with Reset so the line is released without waiting for a clock.
    assign SDA     = (sda_drive_q && !Reset) ? 1'b0 : 1'bz;
    assign TxLoad  = tx_load_q;
    assign RxData  = rx_data_q;
    assign RxValid = rx_valid_q;
    assign Busy    = state_is_busy(state_q);
    assign State   = state_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged master drives SCL and
// an open-drain SDA with a pullup; pulse and bus-activity counters are kept
// by a monitor sampling just after each rising clock edge.
module tb_i2c_slave_responder;
    import i2c_slave_responder_pkg::*;

    localparam int Q = 50;  // quarter SCL period, 5 system clocks

    logic       clock = 1'b0;
    logic       Reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_line;
    logic       tx_load, rx_valid, busy;
    logic [7:0] rx_data;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int slave_low_cnt = 0;
    int busy_cnt = 0;

    pullup(sda_line);
    assign sda_line = m_oe ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    i2c_slave_responder #(
        .SLAVE_ADDR (DEFAULT_SLAVE_ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clock  (clock),
        .Reset  (Reset),
        .SCL    (scl),
        .SDA    (sda_line),
        .TxData (tx_data),
        .TxLoad (tx_load),
        .RxData (rx_data),
        .RxValid(rx_valid),
        .Busy   (busy),
        .State  (state)
    );

    always begin
        @(posedge clock);
        #2;
        if (rx_valid === 1'b1) rxv_cnt++;
        if (tx_load === 1'b1) txl_cnt++;
        if (!m_oe && sda_line === 1'b0) slave_low_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // ---------------- master primitives ----------------
    task automatic m_bit(input logic b, output logic s);
        #Q; m_oe = ~b;
        #Q; scl = 1'b1;
        #Q; s = sda_line;
        #Q; scl = 1'b0;
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            #Q; m_oe = 1'b0;
            #Q; scl = 1'b1;
            #Q;
        end
        m_oe = 1'b1;
        #Q; scl = 1'b0;
    endtask

    task automatic m_stop();
        #Q; m_oe = 1'b1;
        #Q; scl = 1'b1;
        #Q; m_oe = 1'b0;
        #Q;
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic m_read_byte(input logic give_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(~give_ack, s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #40;
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state, ST_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got %b want 0", rx_valid); end
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_txload got %b want 0", tx_load); end
        checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda_line); end
        Reset = 1'b0;
        #100;
    endtask

    task automatic test_write();
        logic a0, a1;
        int rxv0 = rxv_cnt;
        m_start();
        m_write_byte({DEFAULT_SLAVE_ADDR, 1'b0}, a0);
        m_write_byte(8'hA5, a1);
        m_stop();
        #100;
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL wr_addr_ack got %b want 1", a0); end
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL wr_data_ack got %b want 1", a1); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rxdata got %h want a5", rx_data); end
        checks++; if (rxv_cnt - rxv0 != 1) begin errors++; $display("FAIL wr_rxvalid_pulses got %0d want 1", rxv_cnt - rxv0); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL wr_state got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_read();
        logic a0;
        logic [7:0] d;
        int txl0 = txl_cnt;
        tx_data = 8'h3C;
        m_start();
        m_write_byte({DEFAULT_SLAVE_ADDR, 1'b1}, a0);
        m_read_byte(1'b0, d);
        #40;
        checks++; if (state !== ST_IGNORE) begin errors++; $display("FAIL rd_state_nack got %0d want %0d", state, ST_IGNORE); end
        m_stop();
        #100;
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL rd_addr_ack got %b want 1", a0); end
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_data got %h want 3c", d); end
        checks++; if (txl_cnt - txl0 != 1) begin errors++; $display("FAIL rd_txload_pulses got %0d want 1", txl_cnt - txl0); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rd_state got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_wrong_addr();
        logic a0;
        int low0 = slave_low_cnt;
        int busy0 = busy_cnt;
        m_start();
        m_write_byte(8'h92, a0);
        m_stop();
        #100;
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wa_ack got %b want 0", a0); end
        checks++; if (slave_low_cnt != low0) begin errors++; $display("FAIL wa_slave_low got %0d want %0d", slave_low_cnt, low0); end
        checks++; if (busy_cnt != busy0) begin errors++; $display("FAIL wa_busy got %0d want %0d", busy_cnt, busy0); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL wa_state got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int txl0 = txl_cnt;
        tx_data = 8'hC3;
        m_start();
        m_write_byte({DEFAULT_SLAVE_ADDR, 1'b0}, a0);
        m_write_byte(8'h11, a1);
        m_start();
        m_write_byte({DEFAULT_SLAVE_ADDR, 1'b1}, a2);
        #40;            // let the first byte be captured before changing it
        tx_data = 8'h5A;
        m_read_byte(1'b1, d0);
        m_read_byte(1'b0, d1);
        m_stop();
        #100;
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rs_acks got %b want 111", {a0, a1, a2}); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rxdata got %h want 11", rx_data); end
        checks++; if (txl_cnt - txl0 != 2) begin errors++; $display("FAIL rs_txload_pulses got %0d want 2", txl_cnt - txl0); end
        checks++; if (d0 !== 8'hC3) begin errors++; $display("FAIL rs_read0 got %h want c3", d0); end
        checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL rs_read1 got %h want 5a", d1); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rs_state got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_reset_mid_ack();
        logic s;
        logic [7:0] a;
        a = {DEFAULT_SLAVE_ADDR, 1'b0};
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(a[i], s);
        m_oe = 1'b0;
        #Q;
        checks++; if (state !== ST_ADDR_ACK) begin errors++; $display("FAIL rm_state_ack got %0d want %0d", state, ST_ADDR_ACK); end
        checks++; if (sda_line !== 1'b0) begin errors++; $display("FAIL rm_sda_ack got %b want 0", sda_line); end
        #2; Reset = 1'b1;
        #1;
        checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL rm_sda_released got %b want 1", sda_line); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rm_state got %0d want %0d", state, ST_IDLE); end
        #7; scl = 1'b1;
        #20; Reset = 1'b0;
        #100;
    endtask

    task automatic test_abort_mid_byte();
        logic a0, s;
        int rxv0 = rxv_cnt;
        m_start();
        m_write_byte({DEFAULT_SLAVE_ADDR, 1'b0}, a0);
        m_bit(1'b1, s);
        m_bit(1'b0, s);
        m_bit(1'b1, s);
        m_bit(1'b0, s);
        m_stop();
        #100;
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL ab_addr_ack got %b want 1", a0); end
        checks++; if (rxv_cnt != rxv0) begin errors++; $display("FAIL ab_rxvalid got %0d want %0d", rxv_cnt, rxv0); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL ab_state got %0d want %0d", state, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_repeated_start();
        test_reset_mid_ack();
        test_abort_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h48, the 7-bit address this responder acknowledges.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on SCL and SDA inputs (minimum 2).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SCL  input  1  I2C clock driven by the master.
REQ-006 SHALL have port SDA  inout  1  open-drain data line: drives 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL have port TxData  input  8  byte returned to the master on a read.
REQ-008 SHALL have port TxLoad  output  1  one-cycle pulse when TxData is captured.
REQ-009 SHALL have port RxData  output  8  last byte written by the master.
REQ-010 SHALL have port RxValid  output  1  one-cycle pulse when RxData updates.
REQ-011 SHALL have port Busy  output  1  high from an addressed START until STOP, NACK or address mismatch.
REQ-012 SHALL have port State  output  3  current FSM state, for debug and testbench probing.

Function
REQ-013 SCL and SDA SHALL pass through SYNC_STAGES flops; every edge detection SHALL use only synchronized values.
REQ-014 START SHALL be detected as synchronized SDA 1->0 while synchronized SCL is 1; STOP as SDA 0->1 while SCL is 1.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACKCHK, IGNORE.
REQ-016 START in any state, including a repeated START, SHALL move to ADDR and clear the 3-bit bit counter.
REQ-017 STOP in any state SHALL move to IDLE and release SDA on the next clock.
REQ-018 Bits SHALL be sampled MSB first on synchronized SCL rising edges; SDA SHALL change only on the clock after a synchronized SCL falling edge.
REQ-019 ADDR: after 8 bits, address[7:1] == SLAVE_ADDR SHALL go to ADDR_ACK and latch R/W = bit0; a mismatch SHALL go to IGNORE with SDA released.
REQ-020 ADDR_ACK SHALL pull SDA low for exactly one SCL high period, then release it on the following SCL falling edge.
REQ-021 On leaving ADDR_ACK: R/W = 0 SHALL go to RX_BYTE; R/W = 1 SHALL capture TxData, pulse TxLoad, go to TX_BYTE, and drive bit7 at that falling edge.
REQ-022 RX_BYTE: after the 8th rising edge, on the next SCL falling edge, RxData SHALL update, RxValid SHALL pulse once, and the state SHALL go to RX_ACK (SDA low).
REQ-023 RX_ACK SHALL return to RX_BYTE after the ACK clock, so back-to-back written bytes are supported indefinitely.
REQ-024 TX_BYTE SHALL shift out 8 bits (0 = drive low, 1 = release), then release SDA and go to TX_ACKCHK.
REQ-025 TX_ACKCHK: SDA sampled low (master ACK) SHALL reload TxData, pulse TxLoad, and return to TX_BYTE; SDA sampled high (NACK) SHALL go to IGNORE.
REQ-026 IGNORE SHALL keep SDA released and leave only on START or STOP.
REQ-027 Busy SHALL be 1 exactly in ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE and TX_ACKCHK.
REQ-028 START and STOP detected in the same cycle as an SCL edge SHALL take priority over the bit-level action.

Reset
REQ-029 Reset SHALL force the following: State = IDLE, SDA released (z), RxData = 8'h00, RxValid = 0, TxLoad = 0, Busy = 0, bit counter = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately, with no clock edge required.

Structure
REQ-031 A shared package SHALL hold the state encodings and the default SLAVE_ADDR constant, shared by the RTL and the bench.
REQ-032 A sub-module i2c_edge_detect SHALL implement synchronization plus SCL rise/fall and START/STOP detection; the FSM and shift register SHALL live in the top module.

Verification
REQ-033 Bench SHALL model the line with pullup(SDA) and run the master sequence START, 0x90, 0xA5, STOP -> ACK on both bytes, RxData = 8'hA5, exactly one RxValid pulse, State returns to IDLE.
REQ-034 Bench SHALL run START, 0x91 with TxData = 8'h3C, master NACK, STOP -> master reads 0x3C, one TxLoad pulse, IGNORE then IDLE.
REQ-035 Bench SHALL run START, 0x92 (wrong address), STOP -> SDA never driven low by the slave, Busy stays 0.
REQ-036 Bench SHALL run START, 0x90, 0x11, repeated START, 0x91 reading 2 bytes (ACK then NACK) -> RxData = 8'h11, two TxLoad pulses, correct read bytes.
REQ-037 Bench SHALL assert Reset while the slave drives the ADDR_ACK low -> SDA = z within the same cycle, State = IDLE.
REQ-038 Bench SHALL run START, 0x90, then STOP after 4 data bits -> no RxValid pulse, State = IDLE.
